// File: rtl/riscv_test_monitor_pkg.sv
// Shared types and constants for the riscv-tests pass/fail monitor.
package riscv_test_monitor_pkg;

  // Monitor states; PASS, FAIL and TIMEOUT are terminal until clear or rst.
  typedef enum logic [2:0] {
    ST_RUN,
    ST_SETTLE,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  // Encoding of the 2-bit status output.
  localparam logic [1:0] STATUS_RUN     = 2'd0;
  localparam logic [1:0] STATUS_PASS    = 2'd1;
  localparam logic [1:0] STATUS_FAIL    = 2'd2;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

  // ABI register indices used by riscv-tests: gp carries the test number,
  // s10 flags completion and s11 carries the verdict value.
  localparam int REG_GP  = 3;
  localparam int REG_S10 = 26;
  localparam int REG_S11 = 27;

  // Status code for a state; SETTLE still reports RUN.
  function automatic logic [1:0] status_of(input state_e s);
    case (s)
      ST_PASS:    return STATUS_PASS;
      ST_FAIL:    return STATUS_FAIL;
      ST_TIMEOUT: return STATUS_TIMEOUT;
      default:    return STATUS_RUN;
    endcase
  endfunction

endpackage

// File: rtl/riscv_test_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Next count: clear wins, otherwise step unless already at all ones.
  always_comb begin
    // NOTE: assign a default before any condition so no latch is inferred.
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// Snoops the register-file write-back port of the core and reaches a
// sticky pass / fail / timeout verdict for riscv-tests style programs.
module riscv_test_monitor
  import riscv_test_monitor_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter int          DONE_REG       = REG_S10,
  parameter int          RESULT_REG     = REG_S11,
  parameter int          TESTNUM_REG    = REG_GP,
  parameter int unsigned PASS_VALUE     = 1,
  parameter int          SETTLE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [1:0]       status,
  output logic [XLEN-1:0]  test_num,
  output logic [XLEN-1:0]  result_value,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] wb_count
);

  // Parameter sanity, rejected at elaboration.
  if (DONE_REG <= 0 || DONE_REG > 31 || RESULT_REG <= 0 || RESULT_REG > 31 ||
      TESTNUM_REG <= 0 || TESTNUM_REG > 31) begin : g_bad_reg_range
    $error("monitor register indices must be in 1..31");
  end
  if (DONE_REG == RESULT_REG || DONE_REG == TESTNUM_REG ||
      RESULT_REG == TESTNUM_REG) begin : g_bad_reg_alias
    $error("DONE_REG, RESULT_REG and TESTNUM_REG must be distinct");
  end
  if (XLEN < 8 || CNT_W < 8) begin : g_bad_width
    $error("XLEN and CNT_W must both be at least 8");
  end
  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be within 0..255");
  end

  localparam logic [4:0]       DONE_IDX    = 5'(DONE_REG);
  localparam logic [4:0]       RESULT_IDX  = 5'(RESULT_REG);
  localparam logic [4:0]       TESTNUM_IDX = 5'(TESTNUM_REG);
  localparam logic [XLEN-1:0]  PASS_VAL    = XLEN'(PASS_VALUE);
  localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES);
  // Last RUN cycle before the timeout fires; only meaningful when enabled.
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_d, state_q;
  logic [7:0]       settle_d, settle_q;
  logic [XLEN-1:0]  gp_d, gp_q;
  logic [XLEN-1:0]  res_d, res_q;
  logic [1:0]       status_d, status_q;
  logic             done_d, done_q;
  logic             pass_d, pass_q;
  logic             fail_d, fail_q;
  logic             timeout_d, timeout_q;

  logic             live;
  logic             wr_ok;
  logic             done_hit;
  logic             tmo_hit;
  logic             eval_pass;

  // Write qualification shared by the shadows, the FSM and the counters.
  always_comb begin
    live      = (state_q == ST_RUN) || (state_q == ST_SETTLE);
    wr_ok     = wb_we && (wb_rd != 5'd0) && live && !clear;
    done_hit  = wr_ok && (state_q == ST_RUN) && (wb_rd == DONE_IDX) &&
                (wb_data != '0);
    tmo_hit   = (TIMEOUT_CYCLES != 0) && (state_q == ST_RUN) &&
                (cycle_count == TMO_LAST) && !done_hit;
    // The verdict sees a result written on the very edge it is taken.
    eval_pass = (res_d == PASS_VAL);
  end

  // Shadow copies of the test-number and result registers.
  always_comb begin
    gp_d  = gp_q;
    res_d = res_q;
    if (clear) begin
      gp_d  = '0;
      res_d = '0;
    end else if (wr_ok) begin
      if (wb_rd == TESTNUM_IDX) gp_d  = wb_data;
      if (wb_rd == RESULT_IDX)  res_d = wb_data;
    end
  end

  // Next-state logic: RUN -> SETTLE -> verdict, or RUN -> TIMEOUT.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (clear) begin
      state_d  = ST_RUN;
      settle_d = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (done_hit) begin
            if (SETTLE_CYCLES == 0) begin
              state_d = eval_pass ? ST_PASS : ST_FAIL;
            end else begin
              state_d  = ST_SETTLE;
              settle_d = SETTLE_INIT;
            end
          end else if (tmo_hit) begin
            state_d = ST_TIMEOUT;
          end
        end
        ST_SETTLE: begin
          if (settle_q == 8'd1) begin
            state_d  = eval_pass ? ST_PASS : ST_FAIL;
            settle_d = '0;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end
        default: begin
          state_d  = state_q;
          settle_d = settle_q;
        end
      endcase
    end
  end

  // Output decode of the next state so the flags come straight from flops.
  always_comb begin
    status_d  = status_of(state_d);
    done_d    = (status_d != STATUS_RUN);
    pass_d    = (status_d == STATUS_PASS);
    fail_d    = (status_d == STATUS_FAIL) || (status_d == STATUS_TIMEOUT);
    timeout_d = (status_d == STATUS_TIMEOUT);
  end

  // State, settle counter and shadow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      settle_q <= '0;
      gp_q     <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      gp_q     <= gp_d;
      res_q    <= res_d;
    end
  end

  // Registered verdict flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q  <= STATUS_RUN;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      status_q  <= status_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (live),
    .q   (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_wb_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (wr_ok),
    .q   (wb_count)
  );

  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign status       = status_q;
  assign test_num     = gp_q;
  assign result_value = res_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Self-checking bench: three monitor variants share one stimulus stream and
// are compared every cycle against a verdict-level model, plus a directed
// vector table and hand-written multi-cycle sequences.
module tb_riscv_test_monitor;

  localparam int NDUT = 3;
  // Variant 0: settle 1, timeout 50. Variant 1: settle 2, no timeout.
  // Variant 2: settle 0, no timeout, 8-bit counters.
  localparam int SETTLE_P [NDUT] = '{1, 2, 0};
  localparam int TMO_P    [NDUT] = '{50, 0, 0};
  localparam int CNTW_P   [NDUT] = '{32, 32, 8};

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  logic        done_a, pass_a, fail_a, tmo_a;
  logic [1:0]  st_a;
  logic [31:0] tn_a, rv_a, cc_a, wc_a;
  logic        done_b, pass_b, fail_b, tmo_b;
  logic [1:0]  st_b;
  logic [31:0] tn_b, rv_b, cc_b, wc_b;
  logic        done_c, pass_c, fail_c, tmo_c;
  logic [1:0]  st_c;
  logic [31:0] tn_c, rv_c;
  logic [7:0]  cc_c, wc_c;

  riscv_test_monitor #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(50), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .done(done_a), .pass(pass_a), .fail(fail_a),
    .timeout(tmo_a), .status(st_a), .test_num(tn_a), .result_value(rv_a),
    .cycle_count(cc_a), .wb_count(wc_a)
  );

  riscv_test_monitor #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(0), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .done(done_b), .pass(pass_b), .fail(fail_b),
    .timeout(tmo_b), .status(st_b), .test_num(tn_b), .result_value(rv_b),
    .cycle_count(cc_b), .wb_count(wc_b)
  );

  riscv_test_monitor #(.SETTLE_CYCLES(0), .TIMEOUT_CYCLES(0), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .clear(clear), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .done(done_c), .pass(pass_c), .fail(fail_c),
    .timeout(tmo_c), .status(st_c), .test_num(tn_c), .result_value(rv_c),
    .cycle_count(cc_c), .wb_count(wc_c)
  );

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [1:0]  status;
    logic [31:0] tn;
    logic [31:0] rv;
    logic [31:0] cc;
    logic [31:0] wc;
  } obs_t;

  obs_t obs [NDUT];
  assign obs[0] = {done_a, pass_a, fail_a, tmo_a, st_a, tn_a, rv_a, cc_a, wc_a};
  assign obs[1] = {done_b, pass_b, fail_b, tmo_b, st_b, tn_b, rv_b, cc_b, wc_b};
  assign obs[2] = {done_c, pass_c, fail_c, tmo_c, st_c, tn_c, rv_c,
                   24'd0, cc_c, 24'd0, wc_c};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Verdict-level model: verdict 0 running, 1 pass, 2 fail, 3 timeout.
  // settle_left is -1 while no completion has been seen.
  int          m_verdict [NDUT];
  int          m_settle  [NDUT];
  longint      m_cyc     [NDUT];
  longint      m_wb      [NDUT];
  logic [31:0] m_gp      [NDUT];
  logic [31:0] m_res     [NDUT];

  task automatic model_step();
    for (int i = 0; i < NDUT; i++) begin
      longint cmax;
      bit     acc, hit, tmo;
      cmax = (longint'(1) <<< CNTW_P[i]) - 1;
      if (rst || clear) begin
        m_verdict[i] = 0;
        m_settle[i]  = -1;
        m_cyc[i]     = 0;
        m_wb[i]      = 0;
        m_gp[i]      = '0;
        m_res[i]     = '0;
      end else if (m_verdict[i] == 0) begin
        acc = wb_we && (wb_rd != 5'd0);
        hit = acc && (wb_rd == 5'd26) && (wb_data != 32'd0) && (m_settle[i] < 0);
        if (acc) begin
          if (wb_rd == 5'd3)  m_gp[i]  = wb_data;
          if (wb_rd == 5'd27) m_res[i] = wb_data;
          if (m_wb[i] < cmax) m_wb[i] = m_wb[i] + 1;
        end
        tmo = (m_settle[i] < 0) && (TMO_P[i] != 0) &&
              (m_cyc[i] == longint'(TMO_P[i] - 1)) && !hit;
        if (m_cyc[i] < cmax) m_cyc[i] = m_cyc[i] + 1;
        if (m_settle[i] >= 0) begin
          if (m_settle[i] == 1) begin
            m_verdict[i] = (m_res[i] == 32'd1) ? 1 : 2;
            m_settle[i]  = -1;
          end else begin
            m_settle[i] = m_settle[i] - 1;
          end
        end else if (hit) begin
          if (SETTLE_P[i] == 0) m_verdict[i] = (m_res[i] == 32'd1) ? 1 : 2;
          else                  m_settle[i]  = SETTLE_P[i];
        end else if (tmo) begin
          m_verdict[i] = 3;
        end
      end
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("dut%0d.done", i),    64'(obs[i].done),   64'(m_verdict[i] != 0));
      check($sformatf("dut%0d.pass", i),    64'(obs[i].pass),   64'(m_verdict[i] == 1));
      check($sformatf("dut%0d.fail", i),    64'(obs[i].fail),   64'(m_verdict[i] >= 2));
      check($sformatf("dut%0d.timeout", i), 64'(obs[i].tmo),    64'(m_verdict[i] == 3));
      check($sformatf("dut%0d.status", i),  64'(obs[i].status), 64'(m_verdict[i]));
      check($sformatf("dut%0d.test_num", i), 64'(obs[i].tn),    64'(m_gp[i]));
      check($sformatf("dut%0d.result", i),  64'(obs[i].rv),     64'(m_res[i]));
      check($sformatf("dut%0d.cycles", i),  64'(obs[i].cc),     64'(m_cyc[i]));
      check($sformatf("dut%0d.wbs", i),     64'(obs[i].wc),     64'(m_wb[i]));
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic tick(input logic r, input logic c, input logic we,
                      input logic [4:0] rd, input logic [31:0] d);
    rst = r; clear = c; wb_we = we; wb_rd = rd; wb_data = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    tick(1'b0, 1'b0, 1'b1, rd, d);
  endtask

  // Directed vectors against variant 0; expected values hold after the edge.
  typedef struct {
    logic        r;
    logic        c;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [1:0]  st;
    logic [31:0] tn;
    logic [31:0] rv;
    logic [31:0] wc;
  } vec_t;

  vec_t vecs [24];

  initial begin
    rst = 1'b1; clear = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

    //              r     c     we    rd     data          st    tn     rv      wc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'd0,        2'd0, 32'd0, 32'd0,  32'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'd0,        2'd0, 32'd0, 32'd0,  32'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'd3,  32'd5,        2'd0, 32'd5, 32'd0,  32'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd27, 32'd1,        2'd0, 32'd5, 32'd1,  32'd2};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd26, 32'd1,        2'd0, 32'd5, 32'd1,  32'd3};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        2'd1, 32'd5, 32'd1,  32'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        2'd1, 32'd5, 32'd1,  32'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'd3,  32'd9,        2'd1, 32'd5, 32'd1,  32'd3};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        2'd0, 32'd0, 32'd0,  32'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 5'd3,  32'd7,        2'd0, 32'd7, 32'd0,  32'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd27, 32'h0000000E, 2'd0, 32'd7, 32'hE,  32'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 5'd26, 32'd1,        2'd0, 32'd7, 32'hE,  32'd3};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        2'd2, 32'd7, 32'hE,  32'd3};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        2'd0, 32'd0, 32'd0,  32'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 5'd0,  32'd1,        2'd0, 32'd0, 32'd0,  32'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 5'd26, 32'd0,        2'd0, 32'd0, 32'd0,  32'd1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        2'd0, 32'd0, 32'd0,  32'd1};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 5'd27, 32'd1,        2'd0, 32'd0, 32'd1,  32'd2};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 5'd26, 32'd5,        2'd0, 32'd0, 32'd1,  32'd3};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        2'd1, 32'd0, 32'd1,  32'd3};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'd0,        2'd0, 32'd0, 32'd0,  32'd0};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 5'd27, 32'd1,        2'd0, 32'd0, 32'd1,  32'd1};
    vecs[22] = '{1'b0, 1'b1, 1'b1, 5'd26, 32'd1,        2'd0, 32'd0, 32'd0,  32'd0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'd0,        2'd0, 32'd0, 32'd0,  32'd0};

    @(negedge clk);

    for (int v = 0; v < 24; v++) begin
      tick(vecs[v].r, vecs[v].c, vecs[v].we, vecs[v].rd, vecs[v].d);
      check($sformatf("vec%0d.status", v),   64'(st_a), 64'(vecs[v].st));
      check($sformatf("vec%0d.test_num", v), 64'(tn_a), 64'(vecs[v].tn));
      check($sformatf("vec%0d.result", v),   64'(rv_a), 64'(vecs[v].rv));
      check($sformatf("vec%0d.wb_count", v), 64'(wc_a), 64'(vecs[v].wc));
    end

    // Timeout fires on cycle 50 after reset and the cycle count freezes.
    do_reset();
    idle(49);
    check("tmo.cycle49.status", 64'(st_a), 64'(2'd0));
    check("tmo.cycle49.count",  64'(cc_a), 64'd49);
    idle(1);
    check("tmo.cycle50.status",  64'(st_a),   64'(2'd3));
    check("tmo.cycle50.timeout", 64'(tmo_a),  64'd1);
    check("tmo.cycle50.fail",    64'(fail_a), 64'd1);
    check("tmo.cycle50.done",    64'(done_a), 64'd1);
    check("tmo.cycle50.count",   64'(cc_a),   64'd50);
    idle(10);
    check("tmo.frozen.count",  64'(cc_a), 64'd50);
    check("tmo.frozen.status", 64'(st_a), 64'(2'd3));

    // A done write on cycle 49 beats the timeout.
    do_reset();
    idle(49);
    wr(5'd26, 32'd1);
    check("tmo_race.settle.status",  64'(st_a),  64'(2'd0));
    check("tmo_race.settle.timeout", 64'(tmo_a), 64'd0);
    idle(1);
    check("tmo_race.verdict.status",  64'(st_a),  64'(2'd2));
    check("tmo_race.verdict.timeout", 64'(tmo_a), 64'd0);

    // Result written during SETTLE is captured (settle 2); settle 0 decides at once.
    do_reset();
    wr(5'd26, 32'd1);
    check("settle0.immediate.status", 64'(st_c), 64'(2'd2));
    wr(5'd27, 32'd1);
    check("late.settle.status", 64'(st_b), 64'(2'd0));
    idle(1);
    check("late.verdict.status", 64'(st_b),   64'(2'd1));
    check("late.verdict.pass",   64'(pass_b), 64'd1);
    check("late.verdict.result", 64'(rv_b),   64'd1);

    // Saturation of the 8-bit cycle counter while still running.
    do_reset();
    idle(300);
    check("sat.c.cycles", 64'(cc_c), 64'd255);
    check("sat.c.status", 64'(st_c), 64'(2'd0));
    check("sat.b.cycles", 64'(cc_b), 64'd300);

    // Randomized traffic, checked cycle by cycle against the model.
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      logic        r, c, we;
      logic [4:0]  rd;
      logic [31:0] d;
      int          sel;
      r   = ($urandom_range(0, 299) == 0);
      c   = ($urandom_range(0, 59) == 0);
      we  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rd = 5'd0;
        1, 2:    rd = 5'd3;
        3, 4:    rd = 5'd26;
        5, 6:    rd = 5'd27;
        default: rd = 5'($urandom_range(0, 31));
      endcase
      d = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 2)) : 32'($urandom);
      tick(r, c, we, rd, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
Synthesizable monitor that snoops the register-file write-back port of the open_risc_v core and decides pass, fail or timeout for riscv-tests style programs. Completion is signalled by a write to DONE_REG; the verdict compares RESULT_REG with PASS_VALUE. It sits beside open_risc_v inside open_risc_v_soc. It drives benches, FPGA LEDs and a status CSR, replacing hierarchical peeks into the register file.

Parameters:
XLEN, 32, data width of the write-back port
DONE_REG, 26, register index whose nonzero write marks the test as finished
RESULT_REG, 27, register index holding the verdict value
TESTNUM_REG, 3, register index holding the current test number (gp)
PASS_VALUE, 1, RESULT_REG value meaning pass
SETTLE_CYCLES, 1, cycles to wait after done before sampling the result (legal range 0..255)
TIMEOUT_CYCLES, 100000, run-cycle limit; 0 disables the timeout
CNT_W, 32, width of the cycle and write counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
clear  in  1  one-cycle pulse; restarts the monitor in RUN with shadows and counters zeroed
wb_we  in  1  register-file write enable
wb_rd  in  5  register-file write address
wb_data  in  XLEN  register-file write data
done  out  1  sticky; verdict reached (PASS, FAIL or TIMEOUT)
pass  out  1  sticky; RESULT_REG == PASS_VALUE at the sample point
fail  out  1  sticky; the result mismatched, or a timeout occurred
timeout  out  1  sticky; TIMEOUT_CYCLES reached before done
status  out  2  0=RUN, 1=PASS, 2=FAIL, 3=TIMEOUT; SETTLE reports 0
test_num  out  XLEN  shadow of TESTNUM_REG, frozen at the verdict
result_value  out  XLEN  shadow of RESULT_REG, frozen at the verdict
cycle_count  out  CNT_W  cycles spent in RUN+SETTLE, saturating
wb_count  out  CNT_W  accepted write-backs with wb_rd != 0 while in RUN/SETTLE, saturating

Behaviour:
- Reset: state is RUN; all outputs, shadows, counters and the settle count are 0. Monitoring starts on the first cycle after rst deasserts.
- Write acceptance:
  - A write is accepted when wb_we=1, wb_rd!=0 and the state is RUN or SETTLE.
  - A matching index updates its shadow on the same clk edge. Outputs reflect the new value next cycle.
  - Writes to x0 are ignored and not counted.
- State RUN:
  - On an accepted write to DONE_REG with wb_data!=0: go to SETTLE and load settle_cnt=SETTLE_CYCLES.
  - If SETTLE_CYCLES=0, evaluate immediately and go straight to PASS or FAIL.
  - A zero write to DONE_REG only updates its shadow.
- State SETTLE:
  - settle_cnt decrements each cycle.
  - RESULT_REG and TESTNUM_REG shadows keep updating, including a write in the final settle cycle.
  - When settle_cnt reaches 1, the next edge evaluates: shadow result == PASS_VALUE -> PASS, else FAIL.
- Timeout:
  - Applies in RUN only, when TIMEOUT_CYCLES != 0.
  - When cycle_count == TIMEOUT_CYCLES-1 and no done write occurs this cycle, go to TIMEOUT.
  - A done write in that same cycle wins over the timeout.
- PASS, FAIL and TIMEOUT are terminal. Counters and shadows freeze and further writes are ignored; only clear or rst leaves them.
- Flag decode:
  - done = state is PASS, FAIL or TIMEOUT.
  - pass = PASS.
  - fail = FAIL or TIMEOUT.
  - timeout = TIMEOUT.
  - All flags are registered outputs.
- clear:
  - Takes effect at the next edge. It behaves as reset for the whole monitor.
  - A write arriving in the clear cycle is dropped; clear has priority.
  - rst has priority over clear.
- Counters saturate at all ones and never wrap.
- Elaboration-time checks (assertions):
  - DONE_REG, RESULT_REG and TESTNUM_REG are distinct and nonzero.
  - XLEN is at least 8 and CNT_W is at least 8.
  - SETTLE_CYCLES is within 0..255.

Decomposition:
- Package riscv_test_monitor_pkg holds:
  - the state encoding (RUN, SETTLE, PASS, FAIL, TIMEOUT);
  - the 2-bit STATUS_* codes;
  - the REG_GP=3, REG_S10=26 and REG_S11=27 index constants.
- One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, q), is instantiated twice: once for cycle_count and once for wb_count.

Test Plan:
1. Pass: rst for 2 cycles. Then write x3=5, x27=1, x26=1 on consecutive cycles. Required: after SETTLE_CYCLES+1 cycles, status=1, pass=1, done=1, test_num=5, result_value=1, wb_count=3.
2. Fail: write x3=7, x27=0x0000000E, x26=1. Required: status=2, fail=1, pass=0, test_num=7, result_value=0xE.
3. Late result: with SETTLE_CYCLES=2, write x26=1, then x27=1 on the next cycle. Required: PASS, because the write during SETTLE is captured.
4. Timeout: with TIMEOUT_CYCLES=50, issue no writes. Required: timeout=1, fail=1, status=3 on cycle 50 after reset, and cycle_count=50 frozen. Also, a done write on cycle 49 gives PASS/FAIL, not timeout.
5. Boundaries:
   - Write x0=1, then x26=0. Required: no state change, wb_count=1.
   - Pulse clear in PASS. Required: all outputs 0 the next cycle.
   - Assert clear together with a write of x26=1. Required: the write is dropped.
6. Saturation: with CNT_W=8 and TIMEOUT_CYCLES=0, run 300 cycles. Required: cycle_count=255 and still in RUN.
